// File: rtl/snake_pkg.sv
// Shared grid bounds, LFSR constants and coordinate types for the snake game datapath.
// Pure declarations; no timing or backpressure of its own.
package snake_pkg;

   localparam logic [3:0]  GRID_X_MIN    = 4'd1;
   localparam logic [3:0]  GRID_X_MAX    = 4'd14;
   localparam logic [3:0]  GRID_Y_MIN    = 4'd1;
   localparam logic [3:0]  GRID_Y_MAX    = 4'd10;

   localparam logic [15:0] LFSR_TAPS     = 16'hB400;
   localparam logic [15:0] LFSR_SEED     = 16'hACE1;

   localparam logic [3:0]  RCG_MAX_TRIES = 4'd8;

   typedef struct packed {
      logic [3:0] x;
      logic [3:0] y;
   } coord_t;

   typedef enum logic {
      IDLE   = 1'b0,
      SEARCH = 1'b1
   } rcg_state_e;

   // Raster-order successor inside the bounds; anything off-grid restarts at the first cell.
   function automatic coord_t raster_next(input coord_t c,
                                          input logic [3:0] x_min, input logic [3:0] x_max,
                                          input logic [3:0] y_min, input logic [3:0] y_max);
      coord_t n;
      if ((c.x < x_min) || (c.x > x_max) || (c.y < y_min) || (c.y > y_max)) begin
         n.x = x_min;
         n.y = y_min;
      end else if (c.x == x_max) begin
         n.x = x_min;
         n.y = (c.y == y_max) ? y_min : c.y + 4'd1;
      end else begin
         n.x = c.x + 4'd1;
         n.y = c.y;
      end
      return n;
   endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR (shift right) with nonzero load and lock-up recovery.
// Latency: new value visible one edge after step/load; no backpressure.
module lfsr16 #(
   parameter logic [15:0] TAPS  = 16'hB400,
   parameter logic [15:0] SEED  = 16'hACE1,
   parameter int          OUT_W = 16
) (
   input  logic             clk,
   input  logic             nRst,
   input  logic             i_step,
   input  logic             i_load,
   input  logic [15:0]      i_load_val,
   output logic [OUT_W-1:0] o_lfsr
);

   logic [15:0] r_lfsr;
   logic [15:0] w_shift;

   assign w_shift = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);

   // A zero load value would lock the register up, so it is ignored.
   always_ff @(posedge clk) begin
      if (!nRst) begin
         r_lfsr <= SEED;
      end else if (i_load && (i_load_val != 16'h0000)) begin
         r_lfsr <= i_load_val;
      end else if (r_lfsr == 16'h0000) begin
         r_lfsr <= SEED;
      end else if (i_step) begin
         r_lfsr <= w_shift;
      end
   end

   assign o_lfsr = r_lfsr[OUT_W-1:0];

endmodule

// File: rtl/rand_coord_gen.sv
// Rejection-sampled random grid coordinate for the obstacle generator, held between requests.
// Latency: 1..MAX_TRIES edges after req/reject; backpressure: req/reject ignored while busy.
module rand_coord_gen
   import snake_pkg::*;
#(
   parameter logic [3:0]  X_MIN     = GRID_X_MIN,
   parameter logic [3:0]  X_MAX     = GRID_X_MAX,
   parameter logic [3:0]  Y_MIN     = GRID_Y_MIN,
   parameter logic [3:0]  Y_MAX     = GRID_Y_MAX,
   parameter logic [15:0] SEED      = LFSR_SEED,
   parameter logic [3:0]  MAX_TRIES = RCG_MAX_TRIES
) (
   input  logic        clk,
   input  logic        nRst,
   input  logic        s_reset,
   input  logic        req,
   input  logic        reject,
   input  logic        seed_load,
   input  logic [15:0] seed_in,
   output logic [3:0]  randX,
   output logic [3:0]  randY,
   output logic        valid,
   output logic        busy
);

   rcg_state_e r_state;
   rcg_state_e w_state_nxt;
   coord_t     r_held;
   coord_t     w_held_nxt;
   logic       r_valid;
   logic       w_valid_nxt;
   logic [3:0] r_tries;
   logic [3:0] w_tries_nxt;

   logic [7:0] w_lfsr_lo;
   coord_t     w_cand;
   coord_t     w_fallback;
   logic       w_in_range;
   logic       w_accept;
   logic       w_last_try;

   lfsr16 #(
      .TAPS  (LFSR_TAPS),
      .SEED  (SEED),
      .OUT_W (8)
   ) u_lfsr (
      .clk        (clk),
      .nRst       (nRst),
      .i_step     (1'b1),
      .i_load     (seed_load),
      .i_load_val (seed_in),
      .o_lfsr     (w_lfsr_lo)
   );

   assign w_cand.x   = w_lfsr_lo[3:0];
   assign w_cand.y   = w_lfsr_lo[7:4];
   assign w_in_range = (w_cand.x >= X_MIN) && (w_cand.x <= X_MAX) &&
                       (w_cand.y >= Y_MIN) && (w_cand.y <= Y_MAX);
   assign w_accept   = w_in_range && (w_cand != r_held);
   assign w_last_try = (r_tries == (MAX_TRIES - 4'd1));
   assign w_fallback = raster_next(r_held, X_MIN, X_MAX, Y_MIN, Y_MAX);

   always_ff @(posedge clk) begin
      if (!nRst) begin
         r_state <= SEARCH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Game restart re-arms the search but keeps the held cell and lets the LFSR run on.
   always_comb begin
      w_state_nxt = r_state;
      w_held_nxt  = r_held;
      w_valid_nxt = r_valid;
      w_tries_nxt = r_tries;
      if (s_reset) begin
         w_state_nxt = SEARCH;
         w_valid_nxt = 1'b0;
         w_tries_nxt = 4'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req || reject) begin
                  w_state_nxt = SEARCH;
                  w_valid_nxt = 1'b0;
                  w_tries_nxt = 4'd0;
               end
            end
            SEARCH: begin
               if (w_accept) begin
                  w_held_nxt  = w_cand;
                  w_valid_nxt = 1'b1;
                  w_state_nxt = IDLE;
               end else if (w_last_try) begin
                  w_held_nxt  = w_fallback;
                  w_valid_nxt = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_tries_nxt = r_tries + 4'd1;
               end
            end
            default: begin
               w_state_nxt = SEARCH;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!nRst) begin
         r_held  <= '0;
         r_valid <= 1'b0;
         r_tries <= 4'd0;
      end else begin
         r_held  <= w_held_nxt;
         r_valid <= w_valid_nxt;
         r_tries <= w_tries_nxt;
      end
   end

   always_comb begin
      randX = r_held.x;
      randY = r_held.y;
      valid = r_valid;
      busy  = (r_state == SEARCH);
   end

endmodule

// File: tb/tb_rand_coord_gen.sv
// Directed and randomized checks of rand_coord_gen against a behavioural grid/LFSR model.
module tb_rand_coord_gen;

   localparam int MT = 2;

   logic        clk = 1'b0;
   logic        nRst, s_reset, req, reject, seed_load;
   logic [15:0] seed_in;
   logic [3:0]  randX, randY;
   logic        valid, busy;

   int checks = 0;
   int errors = 0;

   // Behavioural model state: raw LFSR word, search flag, draw count, held cell.
   logic [15:0] m_lfsr;
   bit          m_search;
   int          m_tries;
   int          m_x, m_y;
   bit          m_valid;

   rand_coord_gen #(.MAX_TRIES(4'(MT))) dut (
      .clk       (clk),
      .nRst      (nRst),
      .s_reset   (s_reset),
      .req       (req),
      .reject    (reject),
      .seed_load (seed_load),
      .seed_in   (seed_in),
      .randX     (randX),
      .randY     (randY),
      .valid     (valid),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic tick(input bit n, input bit sr, input bit rq, input bit rj,
                       input bit sl, input logic [15:0] si);
      int cx, cy, lin;
      bit ok;
      logic [15:0] nl;
      nRst = n; s_reset = sr; req = rq; reject = rj; seed_load = sl; seed_in = si;
      if (!n) begin
         m_lfsr = 16'hACE1; m_search = 1; m_tries = 0; m_x = 0; m_y = 0; m_valid = 0;
      end else begin
         cx = int'(m_lfsr % 16);
         cy = int'((m_lfsr / 16) % 16);
         if (sl && si != 16'h0) nl = si;
         else if (m_lfsr == 16'h0) nl = 16'hACE1;
         else if (m_lfsr[0]) nl = (m_lfsr >> 1) ^ 16'hB400;
         else nl = m_lfsr >> 1;
         if (sr) begin
            m_search = 1; m_tries = 0; m_valid = 0;
         end else if (!m_search) begin
            if (rq || rj) begin
               m_search = 1; m_tries = 0; m_valid = 0;
            end
         end else begin
            ok = cx >= 1 && cx <= 14 && cy >= 1 && cy <= 10 && !(cx == m_x && cy == m_y);
            if (ok) begin
               m_x = cx; m_y = cy; m_valid = 1; m_search = 0;
            end else if (m_tries == MT - 1) begin
               if (m_x < 1 || m_x > 14 || m_y < 1 || m_y > 10) lin = 0;
               else lin = ((m_y - 1) * 14 + (m_x - 1) + 1) % 140;
               m_x = lin % 14 + 1; m_y = lin / 14 + 1; m_valid = 1; m_search = 0;
            end else begin
               m_tries++;
            end
         end
         m_lfsr = nl;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick(0, 0, 0, 0, 0, 16'h0);
      tick(0, 0, 0, 0, 0, 16'h0);
      checks++; if (randX !== 4'd0) begin errors++; $display("FAIL reset_randX got %0d want 0", randX); end
      checks++; if (randY !== 4'd0) begin errors++; $display("FAIL reset_randY got %0d want 0", randY); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", busy); end
      tick(1, 0, 0, 0, 1, 16'h0035);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL release_valid got %b want 0", valid); end
      tick(1, 0, 0, 0, 0, 16'h0);
      checks++; if (randX !== 4'd5 || randY !== 4'd3) begin errors++; $display("FAIL release_xy got %0d,%0d want 5,3", randX, randY); end
      checks++; if (valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL release_vb got %b%b want 10", valid, busy); end
   endtask

   task automatic test_out_of_range();
      tick(1, 0, 1, 0, 1, 16'h00F5);
      checks++; if (valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL oor_trigger got %b%b want 01", valid, busy); end
      tick(1, 0, 0, 0, 0, 16'h0);
      checks++; if (valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL oor_reject got %b%b want 01", valid, busy); end
      tick(1, 0, 0, 0, 0, 16'h0);
      checks++; if (randX !== 4'd10 || randY !== 4'd7 || valid !== 1'b1) begin
         errors++; $display("FAIL oor_accept got %0d,%0d v%b want 10,7 v1", randX, randY, valid); end
   endtask

   task automatic test_same_as_held();
      tick(1, 0, 1, 0, 1, 16'h007A);
      tick(1, 0, 0, 0, 0, 16'h0);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL same_reject busy got %b want 1", busy); end
      tick(1, 0, 0, 0, 0, 16'h0);
      checks++; if (randX !== 4'd13 || randY !== 4'd3 || valid !== 1'b1) begin
         errors++; $display("FAIL same_accept got %0d,%0d v%b want 13,3 v1", randX, randY, valid); end
   endtask

   task automatic test_fallback();
      tick(1, 0, 1, 0, 1, 16'h00AE);
      tick(1, 0, 0, 0, 0, 16'h0);
      checks++; if (randX !== 4'd14 || randY !== 4'd10) begin errors++; $display("FAIL fb_setup got %0d,%0d want 14,10", randX, randY); end
      tick(1, 0, 1, 0, 1, 16'h0FF0);
      tick(1, 0, 0, 0, 0, 16'h0);
      checks++; if (busy !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL fb_first got %b%b want 01", valid, busy); end
      tick(1, 0, 0, 0, 0, 16'h0);
      checks++; if (randX !== 4'd1 || randY !== 4'd1 || valid !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL fb_wrap got %0d,%0d v%b b%b want 1,1 v1 b0", randX, randY, valid, busy); end
   endtask

   task automatic test_busy_ignore();
      tick(1, 0, 1, 0, 1, 16'h0FF0);
      tick(1, 0, 1, 0, 0, 16'h0);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bi_search got %b want 1", busy); end
      tick(1, 0, 1, 0, 0, 16'h0);
      checks++; if (randX !== 4'd2 || randY !== 4'd1 || valid !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL bi_fallback got %0d,%0d v%b b%b want 2,1 v1 b0", randX, randY, valid, busy); end
      tick(1, 0, 0, 0, 0, 16'h0);
      checks++; if (randX !== 4'd2 || randY !== 4'd1 || valid !== 1'b1) begin
         errors++; $display("FAIL bi_hold got %0d,%0d v%b want 2,1 v1", randX, randY, valid); end
   endtask

   task automatic test_reject_idle();
      logic [3:0] ox, oy;
      int k;
      ox = randX; oy = randY;
      tick(1, 0, 0, 1, 0, 16'h0);
      checks++; if (valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rj_drop got %b%b want 01", valid, busy); end
      k = 0;
      while (busy === 1'b1 && k <= MT) begin
         tick(1, 0, 0, 0, 0, 16'h0);
         k++;
      end
      checks++; if (busy !== 1'b0 || valid !== 1'b1 || k > MT) begin
         errors++; $display("FAIL rj_latency got busy %b after %0d edges want 0 within %0d", busy, k, MT); end
      checks++; if ({randX, randY} === {ox, oy}) begin
         errors++; $display("FAIL rj_distinct got %0d,%0d want different from %0d,%0d", randX, randY, ox, oy); end
      checks++; if (randX !== 4'(m_x) || randY !== 4'(m_y)) begin
         errors++; $display("FAIL rj_model got %0d,%0d want %0d,%0d", randX, randY, m_x, m_y); end
   endtask

   task automatic test_s_reset();
      logic [3:0] ox, oy;
      int k;
      ox = randX; oy = randY;
      tick(1, 0, 1, 0, 1, 16'h0FF0);
      tick(1, 0, 0, 0, 0, 16'h0);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sr_pre busy got %b want 1", busy); end
      tick(1, 1, 0, 0, 0, 16'h0);
      checks++; if (valid !== 1'b0 || busy !== 1'b1 || randX !== ox || randY !== oy) begin
         errors++; $display("FAIL sr_restart got %0d,%0d v%b b%b want %0d,%0d v0 b1", randX, randY, valid, busy, ox, oy); end
      tick(1, 0, 0, 0, 0, 16'h0);
      checks++; if (busy !== 1'b1 || valid !== 1'b0) begin
         errors++; $display("FAIL sr_tries_cleared got v%b b%b want v0 b1", valid, busy); end
      tick(1, 0, 0, 0, 0, 16'h0);
      checks++; if (randX !== 4'd4 || randY !== 4'd1 || valid !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL sr_fallback got %0d,%0d v%b b%b want 4,1 v1 b0", randX, randY, valid, busy); end
      // A zero seed must be ignored: the draw follows the free-running sequence.
      tick(1, 0, 1, 0, 1, 16'h0000);
      k = 0;
      while (busy === 1'b1 && k <= MT) begin
         tick(1, 0, 0, 0, 0, 16'h0);
         k++;
      end
      checks++; if (randX !== 4'(m_x) || randY !== 4'(m_y) || valid !== m_valid || busy !== m_search) begin
         errors++; $display("FAIL zero_seed got %0d,%0d v%b b%b want %0d,%0d v%b b%b",
                            randX, randY, valid, busy, m_x, m_y, m_valid, m_search); end
   endtask

   task automatic test_random();
      bit n, sr, rq, rj, sl;
      logic [15:0] si;
      for (int i = 0; i < 600; i++) begin
         n  = ($urandom % 80) != 0;
         sr = ($urandom % 30) == 0;
         rq = ($urandom % 3) == 0;
         rj = ($urandom % 8) == 0;
         sl = ($urandom % 6) == 0;
         si = (($urandom % 5) == 0) ? 16'h0 : 16'($urandom);
         tick(n, sr, rq, rj, sl, si);
         checks++; if (randX !== 4'(m_x)) begin errors++; $display("FAIL rnd_randX cyc %0d got %0d want %0d", i, randX, m_x); end
         checks++; if (randY !== 4'(m_y)) begin errors++; $display("FAIL rnd_randY cyc %0d got %0d want %0d", i, randY, m_y); end
         checks++; if (valid !== m_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", i, valid, m_valid); end
         checks++; if (busy !== m_search) begin errors++; $display("FAIL rnd_busy cyc %0d got %b want %b", i, busy, m_search); end
      end
   endtask

   initial begin
      test_reset();
      test_out_of_range();
      test_same_as_held();
      test_fallback();
      test_busy_ignore();
      test_reject_idle();
      test_s_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
